add_share_arbiter: RTL and testbench
====================================

# add_share_arbiter

Round-robin arbiter and sequencer that time-shares the single combinational 8-bit `ADD` unit in the ALU among several requesters. It accepts operand pairs over a valid/ready handshake, drives the shared adder's `A`/`B` inputs from registers, and captures `S` into a registered response tagged with the requester ID. The block sits between the datapath stages that need an add (PC increment, address calc, ALU op) and the one physical adder instance.

## Interface

Parameters:
- `N_REQ`, 3: number of requesters (2..4).
- `W`, 8: operand/sum width; must match the `ADD` instance.
- `IDW`, 2: width of requester ID; must satisfy 2^IDW >= N_REQ.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  requester i has an operand pair pending.
- `req_a`  in  N_REQ*W  operand A of requester i in bits [i*W +: W].
- `req_b`  in  N_REQ*W  operand B of requester i in bits [i*W +: W].
- `req_ready`  out  N_REQ  one-hot accept; bit i high means requester i's operands are taken this cycle.
- `add_a`  out  W  registered operand A driven to the shared `ADD.A`.
- `add_b`  out  W  registered operand B driven to the shared `ADD.B`.
- `add_s`  in  W  sum returned from `ADD.S`; combinational from `add_a`/`add_b`.
- `rsp_valid`  out  1  response holds a valid sum.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  W  captured sum, (A+B) mod 2^W.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `ptr` upward mod N_REQ.
  - `req_ready[winner]` is asserted combinationally in the same cycle. All other `req_ready` bits are 0.
  - On the edge: `add_a`/`add_b` <= winner operands, `rsp_id` <= winner, `ptr` <= (winner+1) mod N_REQ, go to EXEC.
  - With no `req_valid` bits set: stay in IDLE and leave `ptr` unchanged.
- EXEC:
  - `req_ready` = 0.
  - On the edge: `rsp_sum` <= `add_s`, `rsp_valid` <= 1, go to RESP.
- RESP:
  - `req_ready` = 0. `rsp_valid`, `rsp_id` and `rsp_sum` hold stable.
  - If `rsp_ready` = 1: `rsp_valid` <= 0 and go to IDLE on the edge.
  - Otherwise stay in RESP. Backpressure is unbounded.
- Arithmetic: unsigned; carry-out is discarded (255+1 -> 0).
- `req_ready` is never asserted outside IDLE, and at most one bit is high at any time.
- A requester that drops `req_valid` before it is granted loses nothing. The arbiter keeps no per-requester state.
- Reset (`rst_n` = 0 at an edge), from any state including mid-EXEC or RESP:
  - State goes to IDLE and any in-flight response is discarded.
  - `ptr` = 0.
  - `add_a` = 0, `add_b` = 0, `rsp_sum` = 0, `rsp_id` = 0, `rsp_valid` = 0.
  - `busy` = 0 and `req_ready` = 0 for the whole reset cycle.

## Timing

- Accept at cycle T (`req_valid[i]` & `req_ready[i]`).
- `add_a`/`add_b` valid at T+1.
- `rsp_valid` = 1 at T+2.
- If `rsp_ready` is high at T+2, the next accept can happen at T+3. Peak throughput is 1 add per 3 cycles.
- `add_s` must settle within one cycle. `ADD` is purely combinational, so there is no multicycle path.
- `busy` is registered and equals (state != IDLE).
- `req_ready` depends combinationally on `req_valid` and `ptr`. There is no path from `rsp_ready` to `req_ready`.

## Test plan

- Reset then single request: `req_valid` = 001, A0 = 10, B0 = 5 -> `req_ready` = 001 at T; `add_a` = 10 and `add_b` = 5 at T+1; `rsp_valid` = 1, `rsp_id` = 0, `rsp_sum` = 15 at T+2.
- Overflow: A1 = 200, B1 = 100 on requester 1 -> `rsp_sum` = 44, `rsp_id` = 1.
- Round robin: all three requesters valid continuously, `rsp_ready` = 1 -> grants in order 0, 1, 2, 0, accepts spaced exactly 3 cycles apart, and each `rsp_sum` matches its requester's operands.
- Backpressure: `rsp_ready` = 0 for 5 cycles in RESP -> `rsp_valid`, `rsp_sum` and `rsp_id` stable, `req_ready` = 000 throughout; the next grant comes 1 cycle after `rsp_ready` goes high.
- Reset mid-op: assert `rst_n` = 0 in EXEC -> next cycle is IDLE with `rsp_valid` = 0 and all outputs 0. After release with requesters 1 and 2 valid, the first grant goes to requester 1 (`ptr` = 0).
- Idle hold: `req_valid` = 000 for 10 cycles -> `busy` = 0, `req_ready` = 000, `ptr` unchanged (checked via the next grant order).

Source files
------------

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational adder among N_REQ requesters.
// Operands are registered toward the adder and the sum is captured into a tagged response.
module add_share_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned W     = 8,
    parameter int unsigned IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic [W-1:0]       add_s,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           busy_q;

    logic           found_hi, found_lo, found;
    logic [IDW-1:0] hi_idx, lo_idx, winner;
    logic [W-1:0]   a_win, b_win;
    logic [N_REQ-1:0] grant;

    // Winner is the lowest valid index at or above ptr, else the lowest valid index below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_valid[i]) begin
                if (IDW'(i) >= ptr_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        hi_idx   = IDW'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        found  = found_hi | found_lo;
        winner = found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        a_win = '0;
        b_win = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (IDW'(i) == winner) begin
                a_win = req_a[i*W +: W];
                b_win = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        grant       = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        grant[i] = (IDW'(i) == winner);
                    end
                    add_a_d  = a_win;
                    add_b_d  = b_win;
                    rsp_id_d = winner;
                    ptr_d    = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                rsp_sum_d   = add_s;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    // Reset masks the accept and busy outputs for the entire reset cycle, not just after the edge.
    assign req_ready = rst_n ? grant : '0;
    assign busy      = busy_q & rst_n;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter: expected (id, sum) pairs queued on each grant
// and compared when the response is consumed.
module tb_add_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [2:0]  req_ready;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_s;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        busy;

    logic [7:0] op_a [3];
    logic [7:0] op_b [3];

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    assign req_a = {op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[2], op_b[1], op_b[0]};
    assign add_s = add_a + add_b;

    add_share_arbiter #(.N_REQ(3), .W(8), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 2'(id);
        e.sum = op_a[id] + op_b[id];
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 3'b111; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin op_a[i] = 8'd0; op_b[i] = 8'd0; end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: req_ready=%b busy=%b, required 000/0", req_ready, busy);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, add_a, add_b} !== 27'd0) begin
            errors++;
            $display("FAIL reset_regs: v=%b id=%0d sum=%0d a=%0d b=%0d, required all 0",
                     rsp_valid, rsp_id, rsp_sum, add_a, add_b);
        end
        next_cycle();
        rst_n = 1'b1; req_valid = 3'b000;
    endtask

    task automatic test_single();
        exp_t e;
        op_a[0] = 8'd10; op_b[0] = 8'd5; req_valid = 3'b001; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL single_grant: req_ready=%b, required 001", req_ready);
        end
        push_exp(0);
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (add_a !== 8'd10 || add_b !== 8'd5 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_exec: a=%0d b=%0d busy=%b v=%b, required 10/5/1/0",
                     add_a, add_b, busy, rsp_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'd15) begin
            errors++; $display("FAIL single_rsp: v=%b sum=%0d, required 1/15", rsp_valid, rsp_sum);
        end
        checks++;
        e = exp_q.pop_front();
        if (rsp_id !== e.id || rsp_sum !== e.sum) begin
            errors++; $display("FAIL single_sb: id=%0d sum=%0d, required %0d/%0d",
                               rsp_id, rsp_sum, e.id, e.sum);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: busy=%b v=%b, required 0/0", busy, rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_overflow();
        exp_t e;
        op_a[1] = 8'd200; op_b[1] = 8'd100; req_valid = 3'b010; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL ovf_grant: req_ready=%b, required 010", req_ready);
        end
        push_exp(1);
        next_cycle();
        req_valid = 3'b000;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'd44 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL ovf_rsp: v=%b sum=%0d id=%0d, required 1/44/1",
                               rsp_valid, rsp_sum, rsp_id);
        end
        checks++;
        e = exp_q.pop_front();
        if (rsp_id !== e.id || rsp_sum !== e.sum) begin
            errors++; $display("FAIL ovf_sb: id=%0d sum=%0d, required %0d/%0d",
                               rsp_id, rsp_sum, e.id, e.sum);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   grants = 0;
        int   last   = 0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a[i] = 8'($urandom); op_b[i] = 8'($urandom);
        end
        req_valid = 3'b111; rsp_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++; $display("FAIL rr_onehot: req_ready=%b, required at most one bit", req_ready);
            end
            if (req_ready !== 3'b000) begin
                checks++;
                if (req_ready !== 3'(1 << (grants % 3))) begin
                    errors++; $display("FAIL rr_order: grant %0d req_ready=%b, required %b",
                                       grants, req_ready, 3'(1 << (grants % 3)));
                end
                if (grants > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        errors++; $display("FAIL rr_spacing: gap=%0d, required 3", c - last);
                    end
                end
                last = c;
                push_exp(grants % 3);
                grants++;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_extra_rsp: id=%0d sum=%0d, required none", rsp_id, rsp_sum);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                        errors++; $display("FAIL rr_sb: id=%0d sum=%0d, required %0d/%0d",
                                           rsp_id, rsp_sum, e.id, e.sum);
                    end
                end
            end
            next_cycle();
            if (grants == 4) req_valid = 3'b000;
        end
        checks++;
        if (grants != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL rr_count: grants=%0d pending=%0d, required 4/0", grants, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [7:0] held_sum;
        logic [1:0] held_id;
        op_a[2] = 8'($urandom); op_b[2] = 8'($urandom);
        req_valid = 3'b100; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++; $display("FAIL bp_grant: req_ready=%b, required 100", req_ready);
        end
        push_exp(2);
        next_cycle();
        req_valid = 3'b000;
        next_cycle();
        @(negedge clk);
        held_sum = rsp_sum;
        held_id  = rsp_id;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_rsp_valid: v=%b, required 1", rsp_valid);
        end
        next_cycle();
        req_valid = 3'b111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== held_sum || rsp_id !== held_id || req_ready !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold: cyc %0d v=%b sum=%0d id=%0d rdy=%b, required 1/%0d/%0d/000",
                         c, rsp_valid, rsp_sum, rsp_id, req_ready, held_sum, held_id);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        e = exp_q.pop_front();
        if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum) begin
            errors++; $display("FAIL bp_sb: v=%b id=%0d sum=%0d, required 1/%0d/%0d",
                               rsp_valid, rsp_id, rsp_sum, e.id, e.sum);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL bp_regrant: req_ready=%b, required 001", req_ready);
        end
        push_exp(0);
        next_cycle();
        req_valid = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                    errors++; $display("FAIL bp_drain: id=%0d sum=%0d, required %0d/%0d",
                                       rsp_id, rsp_sum, e.id, e.sum);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL bp_timeout: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        op_a[1] = 8'($urandom); op_b[1] = 8'($urandom);
        op_a[2] = 8'($urandom); op_b[2] = 8'($urandom);
        req_valid = 3'b010; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL rm_grant: req_ready=%b, required 010", req_ready);
        end
        push_exp(1);
        next_cycle();
        req_valid = 3'b111; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_in_reset: req_ready=%b busy=%b, required 000/0", req_ready, busy);
        end
        next_cycle();
        rst_n = 1'b1; req_valid = 3'b110;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, add_a, add_b, busy} !== 28'd0) begin
            errors++;
            $display("FAIL rm_cleared: v=%b id=%0d sum=%0d a=%0d b=%0d busy=%b, required all 0",
                     rsp_valid, rsp_id, rsp_sum, add_a, add_b, busy);
        end
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL rm_ptr: req_ready=%b, required 010", req_ready);
        end
        push_exp(1);
        next_cycle();
        req_valid = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                    errors++; $display("FAIL rm_drain: id=%0d sum=%0d, required %0d/%0d",
                                       rsp_id, rsp_sum, e.id, e.sum);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rm_timeout: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_idle_hold();
        exp_t e;
        req_valid = 3'b000; rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || req_ready !== 3'b000) begin
                errors++; $display("FAIL idle_hold: cyc %0d busy=%b req_ready=%b, required 0/000",
                                   c, busy, req_ready);
            end
            next_cycle();
        end
        op_a[2] = 8'd255; op_b[2] = 8'd1;
        req_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++; $display("FAIL idle_ptr: req_ready=%b, required 100", req_ready);
        end
        push_exp(2);
        next_cycle();
        req_valid = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                    errors++; $display("FAIL idle_drain: id=%0d sum=%0d, required %0d/%0d",
                                       rsp_id, rsp_sum, e.id, e.sum);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL idle_timeout: pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_idle_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
